// File: rtl/fifo_sync_wm.sv
// fifo_sync_wm: single-clock FIFO with valid/ready on both sides, optional
// write-to-read pass-through, programmable almost-full/almost-empty
// watermarks, registered watermark-crossing event pulses and an optional
// sticky peak-occupancy tracker.
//
// Build option:
//   FIFO_SYNC_WM_PEAK_EN  defined   -> peak tracker implemented
//                         undefined -> peak_o tied to 0, peak_clr_i unused
//
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   clr_i                     synchronous flush (overrides handshakes)
//   wvalid_i/wready_o/wdata_i write side handshake and data
//   rvalid_o/rready_i/rdata_o read side handshake and data
//   depth_o                   number of stored entries
//   wm_full_lvl_i             almost-full threshold  (almost_full_o  = depth_o >= lvl)
//   wm_empty_lvl_i            almost-empty threshold (almost_empty_o = depth_o <= lvl)
//   full_evt_o/empty_evt_o    one-cycle pulses, the cycle after a flag rises
//   peak_clr_i/peak_o         peak tracker clear and maximum depth since clear

module fifo_sync_wm #(
    parameter int unsigned Width             = 16,
    parameter int unsigned Depth             = 4,
    parameter bit          Pass              = 1'b1,
    parameter bit          OutputZeroIfEmpty = 1'b1,
    localparam int unsigned DepthW = (Depth + 1 == 1) ? 1 : $clog2(Depth + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              wvalid_i,
    output logic              wready_o,
    input  logic [Width-1:0]  wdata_i,
    output logic              rvalid_o,
    input  logic              rready_i,
    output logic [Width-1:0]  rdata_o,
    output logic [DepthW-1:0] depth_o,
    input  logic [DepthW-1:0] wm_full_lvl_i,
    input  logic [DepthW-1:0] wm_empty_lvl_i,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic              full_evt_o,
    output logic              empty_evt_o,
    input  logic              peak_clr_i,
    output logic [DepthW-1:0] peak_o
);

    localparam int unsigned PtrVW = (Depth == 1) ? 1 : $clog2(Depth);

    if (Depth == 0) begin : gen_bad_depth
        $error("fifo_sync_wm: Depth must be >= 1");
    end

    // Pointers carry an extra wrap bit above a low field that wraps at Depth-1,
    // so non-power-of-two depths still distinguish full from empty.
    logic [PtrVW:0]   r_wptr;
    logic [PtrVW:0]   r_rptr;
    logic [PtrVW-1:0] w_wlow;
    logic [PtrVW-1:0] w_rlow;
    logic             w_full;
    logic             w_empty;
    logic             w_pass;
    logic             w_wr;
    logic             w_rd;
    logic [Width-1:0] w_rdata_raw;
    logic [DepthW-1:0] w_depth;

    logic [Width-1:0] r_mem [Depth];

    function automatic logic [PtrVW:0] ptr_inc(input logic [PtrVW:0] p);
        logic [PtrVW:0] n;
        if (p[PtrVW-1:0] == PtrVW'(Depth - 1)) begin
            n = {~p[PtrVW], {PtrVW{1'b0}}};
        end else begin
            n = {p[PtrVW], p[PtrVW-1:0] + PtrVW'(1)};
        end
        return n;
    endfunction

    assign w_wlow  = r_wptr[PtrVW-1:0];
    assign w_rlow  = r_rptr[PtrVW-1:0];
    assign w_full  = (w_wlow == w_rlow) && (r_wptr[PtrVW] != r_rptr[PtrVW]);
    assign w_empty = (r_wptr == r_rptr);

    // Pass-through: an empty FIFO presents the incoming write directly.
    assign w_pass   = Pass && w_empty && wvalid_i;
    assign wready_o = ~w_full;
    assign rvalid_o = ~w_empty | w_pass;
    assign w_wr     = wvalid_i & ~w_full;
    assign w_rd     = rvalid_o & rready_i;

    assign w_rdata_raw = w_pass ? wdata_i : r_mem[w_rlow];
    assign rdata_o     = (OutputZeroIfEmpty && !rvalid_o) ? '0 : w_rdata_raw;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (clr_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) r_wptr <= ptr_inc(r_wptr);
            if (w_rd) r_rptr <= ptr_inc(r_rptr);
        end
    end

    // Storage needs no reset; a passed-through write also lands here harmlessly.
    always_ff @(posedge clk_i) begin
        if (w_wr) r_mem[w_wlow] <= wdata_i;
    end

    always_comb begin
        w_depth = '0;
        if (w_full) begin
            w_depth = DepthW'(Depth);
        end else if (r_wptr[PtrVW] == r_rptr[PtrVW]) begin
            w_depth = DepthW'(w_wlow) - DepthW'(w_rlow);
        end else begin
            w_depth = DepthW'(Depth) - DepthW'(w_rlow) + DepthW'(w_wlow);
        end
    end

    assign depth_o        = w_depth;
    assign almost_full_o  = (w_depth >= wm_full_lvl_i);
    assign almost_empty_o = (w_depth <= wm_empty_lvl_i);

    // Edge detection against last cycle's flags; a flush simply shows up as a
    // new depth next cycle, so it can raise empty_evt_o like any other drop.
    logic r_af_q;
    logic r_ae_q;
    logic r_full_evt;
    logic r_empty_evt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_af_q      <= 1'b0;
            r_ae_q      <= 1'b1;
            r_full_evt  <= 1'b0;
            r_empty_evt <= 1'b0;
        end else begin
            r_af_q      <= almost_full_o;
            r_ae_q      <= almost_empty_o;
            r_full_evt  <= almost_full_o & ~r_af_q;
            r_empty_evt <= almost_empty_o & ~r_ae_q;
        end
    end

    assign full_evt_o  = r_full_evt;
    assign empty_evt_o = r_empty_evt;

`ifdef FIFO_SYNC_WM_PEAK_EN
    logic [DepthW-1:0] r_peak;

    // A flush loads the post-flush depth (0); a peak clear loads the current depth.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_peak <= '0;
        end else if (clr_i) begin
            r_peak <= '0;
        end else if (peak_clr_i) begin
            r_peak <= w_depth;
        end else if (w_depth > r_peak) begin
            r_peak <= w_depth;
        end
    end

    assign peak_o = r_peak;
`else
    logic w_unused_peak_clr;
    assign w_unused_peak_clr = peak_clr_i;
    assign peak_o            = '0;
`endif

endmodule

// File: doc/fifo_sync_wm.md
Name: fifo_sync_wm

Overview:
- Synchronous single-clock FIFO with valid/ready handshakes on both sides and optional write-to-read pass-through.
- Adds programmable almost-full and almost-empty watermarks, one-cycle watermark-crossing event pulses, and a sticky peak-occupancy (high-water) tracker.
- Used between TL-UL adapters and peripheral datapaths where firmware-visible fill levels and interrupt sources are needed.

Parameters:
- Width, 16, data width in bits (>=1).
- Depth, 4, number of entries; must be >=1, and Depth=0 is an elaboration error.
- Pass, 1'b1, when 1, a write into an empty FIFO is visible on the read side in the same cycle.
- OutputZeroIfEmpty, 1'b1, when 1, rdata_o is driven to 0 whenever rvalid_o=0.
- DepthW, derived = (Depth+1==1 ? 1 : $clog2(Depth+1)), width of all level and occupancy signals; this is a localparam, not overridable.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- clr_i  in  1  synchronous flush
- wvalid_i  in  1  write request
- wready_o  out  1  space available
- wdata_i  in  Width  write data
- rvalid_o  out  1  read data valid
- rready_i  in  1  read accept
- rdata_o  out  Width  read data
- depth_o  out  DepthW  stored entry count
- wm_full_lvl_i  in  DepthW  almost-full threshold
- wm_empty_lvl_i  in  DepthW  almost-empty threshold
- almost_full_o  out  1  depth_o >= wm_full_lvl_i
- almost_empty_o  out  1  depth_o <= wm_empty_lvl_i
- full_evt_o  out  1  one-cycle pulse on rising almost_full_o
- empty_evt_o  out  1  one-cycle pulse on rising almost_empty_o
- peak_clr_i  in  1  clear peak tracker
- peak_o  out  DepthW  maximum depth_o since last clear

Behaviour:
- Reset: rst_ni is asynchronous, active-low; clock is clk_i. On reset, both pointers are 0, so depth_o=0, wready_o=1, rvalid_o=0 (or =wvalid_i if Pass), rdata_o=0 (when OutputZeroIfEmpty). Also on reset: full_evt_o=0, empty_evt_o=0, peak_o=0, and the previous-state registers are almost_full_q=0, almost_empty_q=1.
- Pointers: wptr and rptr are (PTRV_W+1) bits, where PTRV_W = Depth==1 ? 1 : $clog2(Depth). The low field wraps from Depth-1 to 0 and toggles the MSB, so non-power-of-two Depth is supported.
  - full: low fields equal, MSBs differ.
  - empty: pointers equal.
- Handshakes:
  - Write accepted when wvalid_i & wready_o; wready_o = ~full, with no combinational path from rready_i.
  - Read accepted when rvalid_o & rready_i.
  - Storage is a register array written on write accept; read data is combinational from rptr.
- depth_o:
  - When full: Depth.
  - When MSBs equal: wptr_low - rptr_low.
  - Otherwise: Depth - rptr_low + wptr_low.
  - All arithmetic is in DepthW bits.
- Pass=1, empty FIFO, wvalid_i=1:
  - rvalid_o=1 and rdata_o=wdata_i in the same cycle.
  - If rready_i=1 too, both pointers advance and depth_o stays 0.
- Simultaneous read and write when neither full nor empty: both occur, depth_o unchanged.
- Full with a read: wready_o stays 0 that cycle; the slot frees next cycle.
- clr_i: both pointers go to 0 next cycle. clr_i overrides any concurrent handshakes, and storage contents are don't-care.
  - Event registers re-evaluate from the post-clear depth. A clear that makes almost_empty_o rise generates empty_evt_o.
- Watermarks:
  - almost_full_o and almost_empty_o are combinational from depth_o and the threshold inputs; thresholds may change any cycle.
  - wm_full_lvl_i=0 gives almost_full_o=1 constantly.
  - A threshold > Depth means the flag never asserts (almost_full_o) or always asserts (almost_empty_o).
- Events:
  - almost_full_q and almost_empty_q are registered copies of the flags.
  - full_evt_o = almost_full_o & ~almost_full_q; empty_evt_o is the same form on the almost-empty flags.
  - Both event outputs are registered, so each pulse appears the cycle after the crossing.
- Peak tracker:
  - Every cycle, peak_q <= max(peak_q, depth_o).
  - peak_clr_i or clr_i loads the current depth_o (after clear, 0). Clear has priority over update.

Optional Feature:
- Macro: FIFO_SYNC_WM_PEAK_EN.
- Defined: the peak tracker is implemented as above.
- Undefined: there are no peak registers, peak_o is tied to 0, and peak_clr_i is unused (sunk to an unused wire). All other behaviour is identical.

Test Plan:
- Config Width=8, Depth=4, Pass=0. Write 0x11, 0x22, 0x33, 0x44 with rready_i=0 -> depth_o=1, 2, 3, 4; wready_o=0 after the 4th; reads return 0x11..0x44 in order; depth_o returns to 0.
- Config Depth=3. Run 10 write/read pairs, one in flight -> pointers wrap correctly; data order is preserved; depth_o is never >1; no false full.
- Config Pass=1, empty FIFO. wvalid_i=1, wdata_i=0xA5, rready_i=1 -> same-cycle rvalid_o=1, rdata_o=0xA5; depth_o stays 0.
- Config wm_full_lvl_i=3, wm_empty_lvl_i=1, Depth=4. Fill to 3 -> full_evt_o pulses once, one cycle after depth_o hits 3. Drain to 1 -> empty_evt_o pulses once. Hold the level -> no further pulses.
- Fill to 4, drain to 1 -> peak_o=4. Assert peak_clr_i -> peak_o=1 next cycle. Assert clr_i -> depth_o=0 and peak_o=0 next cycle.
- Assert rst_ni low mid-burst with depth_o=2 -> all outputs return to reset values immediately (async); rdata_o=0.
